// File: rtl/lpif_gearbox_pkg.sv
// Record layout, width helpers and shared types
// for the LPIF <-> logic-link gearbox.
package lpif_gearbox_pkg;

  localparam int LPIF_DATA_W = 64;
  localparam int LPIF_CRC_W  = 2;

  localparam int OFF_STATE  = 0;
  localparam int OFF_PROTID = 4;
  localparam int OFF_DATA   = 6;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  crc_valid;
    logic [LPIF_CRC_W-1:0] crc;
    logic                  dvalid;
    logic [LPIF_DATA_W-1:0] data;
    logic [1:0]            protid;
    logic [3:0]            state;
  } lpif_rec_t;

  function automatic int off_dvalid(int dw);
    return OFF_DATA + dw;
  endfunction

  function automatic int off_crc(int dw);
    return OFF_DATA + dw + 1;
  endfunction

  function automatic int off_crcv(int dw, int cw);
    return off_crc(dw) + cw;
  endfunction

  function automatic int off_valid(int dw, int cw);
    return off_crcv(dw, cw) + 1;
  endfunction

  function automatic int rec_w(int dw, int cw);
    return dw + cw + 9;
  endfunction

  function automatic int pay_w(int dw, int cw, int r);
    return (rec_w(dw, cw) + r - 1) / r;
  endfunction

  function automatic int slice_w(int dw, int cw, int r);
    return pay_w(dw, cw, r) + 1;
  endfunction

  // Marker sits directly above the payload bits.
  function automatic int marker_bit(int dw, int cw, int r);
    return pay_w(dw, cw, r);
  endfunction

  function automatic int idx_w(int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/lpif_gearbox_rx_align.sv
// RX slice counter, record assembly and marker
// alignment checking for the LPIF gearbox.
module lpif_gearbox_rx_align
  import lpif_gearbox_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CRC_W  = 2,
  parameter int RATIO  = 2,
  localparam int REC_W   = rec_w(DATA_W, CRC_W),
  localparam int PAY_W   = pay_w(DATA_W, CRC_W, RATIO),
  localparam int SLICE_W = slice_w(DATA_W, CRC_W, RATIO)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [SLICE_W-1:0] slice_i,
  input  logic               push_i,
  output logic [REC_W-1:0]   rec_o,
  output logic               rec_push_o,
  output logic               align_err_o
);

  localparam int IDX_W = idx_w(RATIO);
  localparam int MRK   = marker_bit(DATA_W, CRC_W, RATIO);

  logic [RATIO*PAY_W-1:0] asm_q, asm_d;
  logic [IDX_W-1:0]       idx_q, idx_d, slot;
  logic [REC_W-1:0]       rec_q, rec_d;
  logic                   push_q, push_d;
  logic                   err_q, err_d;
  logic                   marker;
  logic [PAY_W-1:0]       pay;

  assign marker = slice_i[MRK];
  assign pay    = slice_i[PAY_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q  <= '0;
      idx_q  <= '0;
      rec_q  <= '0;
      push_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      idx_q  <= idx_d;
      rec_q  <= rec_d;
      push_q <= push_d;
      err_q  <= err_d;
    end
  end

  // A marker restarts assembly at slot 0, dropping any partial record.
  always_comb begin
    asm_d  = asm_q;
    idx_d  = idx_q;
    rec_d  = rec_q;
    push_d = 1'b0;
    err_d  = 1'b0;
    slot   = idx_q;
    if (push_i) begin
      if (marker) begin
        err_d = (idx_q != '0);
        slot  = '0;
      end else if (idx_q == '0) begin
        err_d = 1'b1;
      end
      if (marker || (idx_q != '0)) begin
        asm_d[slot*PAY_W +: PAY_W] = pay;
        if (slot == IDX_W'(RATIO - 1)) begin
          idx_d  = '0;
          rec_d  = asm_d[REC_W-1:0];
          push_d = 1'b1;
        end else begin
          idx_d = slot + 1'b1;
        end
      end
    end
  end

  assign rec_o       = rec_q;
  assign rec_push_o  = push_q;
  assign align_err_o = err_q;

endmodule

// File: rtl/lpif_txrx_gearbox.sv
// LPIF record <-> RATIO logic-link slice gearbox,
// TX packer FSM plus RX aligner, single clock.
module lpif_txrx_gearbox
  import lpif_gearbox_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CRC_W  = 2,
  parameter int RATIO  = 2,
  localparam int REC_W   = rec_w(DATA_W, CRC_W),
  localparam int PAY_W   = pay_w(DATA_W, CRC_W, RATIO),
  localparam int SLICE_W = slice_w(DATA_W, CRC_W, RATIO)
) (
  input  logic               clk_wr,
  input  logic               rst_wr_n,
  input  logic [3:0]         ustrm_state,
  input  logic [1:0]         ustrm_protid,
  input  logic [DATA_W-1:0]  ustrm_data,
  input  logic               ustrm_dvalid,
  input  logic [CRC_W-1:0]   ustrm_crc,
  input  logic               ustrm_crc_valid,
  input  logic               ustrm_valid,
  input  logic               ustrm_push,
  output logic               ustrm_ready,
  output logic [SLICE_W-1:0] txfifo_upstream_data,
  output logic               txfifo_upstream_push,
  input  logic               txfifo_upstream_ready,
  input  logic [SLICE_W-1:0] rxfifo_downstream_data,
  input  logic               rxfifo_downstream_push,
  output logic [3:0]         dstrm_state,
  output logic [1:0]         dstrm_protid,
  output logic [DATA_W-1:0]  dstrm_data,
  output logic               dstrm_dvalid,
  output logic [CRC_W-1:0]   dstrm_crc,
  output logic               dstrm_crc_valid,
  output logic               dstrm_valid,
  output logic               dstrm_push,
  output logic               rx_align_err
);

  localparam int IDX_W = idx_w(RATIO);
  localparam int MRK   = marker_bit(DATA_W, CRC_W, RATIO);

  if (!(RATIO == 1 || RATIO == 2 || RATIO == 4)) begin : g_bad_ratio
    $error("lpif_txrx_gearbox: RATIO must be 1, 2 or 4");
  end

  tx_state_e              state_q, state_d;
  logic [REC_W-1:0]       rec_q, rec_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   rdy_en_q;
  logic [REC_W-1:0]       ustrm_rec;
  logic [RATIO*PAY_W-1:0] pad;
  logic                   last, slice_ack, accept;

  assign ustrm_rec = {ustrm_valid, ustrm_crc_valid, ustrm_crc,
                      ustrm_dvalid, ustrm_data, ustrm_protid,
                      ustrm_state};
  assign last      = (idx_q == IDX_W'(RATIO - 1));
  assign slice_ack = (state_q == TX_SEND) & txfifo_upstream_ready;
  assign accept    = ustrm_push & ustrm_ready;

  // rdy_en_q keeps ustrm_ready low until the first edge after reset.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q  <= TX_IDLE;
      rec_q    <= '0;
      idx_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rec_q    <= rec_d;
      idx_q    <= idx_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    idx_d   = idx_q;
    unique case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d = TX_SEND;
          rec_d   = ustrm_rec;
          idx_d   = '0;
        end
      end
      TX_SEND: begin
        if (slice_ack) begin
          if (!last) begin
            idx_d = idx_q + 1'b1;
          end else if (accept) begin
            rec_d = ustrm_rec;
            idx_d = '0;
          end else begin
            state_d = TX_IDLE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    pad = '0;
    pad[REC_W-1:0] = rec_q;
    ustrm_ready = rdy_en_q &
                  ((state_q == TX_IDLE) | (slice_ack & last));
    txfifo_upstream_push = (state_q == TX_SEND);
    txfifo_upstream_data = '0;
    if (txfifo_upstream_push) begin
      txfifo_upstream_data[PAY_W-1:0] = pad[idx_q*PAY_W +: PAY_W];
      txfifo_upstream_data[MRK]       = (idx_q == '0);
    end
  end

  logic [REC_W-1:0] rx_rec;

  lpif_gearbox_rx_align #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .RATIO  (RATIO)
  ) u_rx (
    .clk_i       (clk_wr),
    .rst_ni      (rst_wr_n),
    .slice_i     (rxfifo_downstream_data),
    .push_i      (rxfifo_downstream_push),
    .rec_o       (rx_rec),
    .rec_push_o  (dstrm_push),
    .align_err_o (rx_align_err)
  );

  assign dstrm_state     = rx_rec[OFF_STATE +: 4];
  assign dstrm_protid    = rx_rec[OFF_PROTID +: 2];
  assign dstrm_data      = rx_rec[OFF_DATA +: DATA_W];
  assign dstrm_dvalid    = rx_rec[off_dvalid(DATA_W)];
  assign dstrm_crc       = rx_rec[off_crc(DATA_W) +: CRC_W];
  assign dstrm_crc_valid = rx_rec[off_crcv(DATA_W, CRC_W)];
  assign dstrm_valid     = rx_rec[off_valid(DATA_W, CRC_W)];

endmodule

// File: tb/tb_lpif_txrx_gearbox.sv
// Randomised bench for lpif_txrx_gearbox at RATIO 1/2/4
// against a queue-based slicing/reassembly model.
module tb_lpif_txrx_gearbox;

  localparam int RW = 75;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          push_pct [3];
  int          rdy_pct  [3];
  bit          loop_en  [3];
  bit          inj_v    [3];
  logic [75:0] inj_d    [3];
  bit          dir_v = 1'b0;
  bit          done  = 1'b0;
  bit          rdy_en = 1'b0;
  logic [RW-1:0] dir_rec;

  always @(posedge clk or negedge rst_n) rdy_en <= rst_n;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int R  = 1 << g;
    localparam int PW = (RW + R - 1) / R;
    localparam int SW = PW + 1;

    logic [3:0]  us_state;
    logic [1:0]  us_protid;
    logic [63:0] us_data;
    logic        us_dvalid;
    logic [1:0]  us_crc;
    logic        us_crcv, us_valid, us_push, us_ready;
    logic [SW-1:0] txd, rxd;
    logic        txp, txr, rxp;
    logic [3:0]  ds_state;
    logic [1:0]  ds_protid;
    logic [63:0] ds_data;
    logic        ds_dvalid;
    logic [1:0]  ds_crc;
    logic        ds_crcv, ds_valid, ds_push, aerr;
    logic [RW-1:0] urec, drec;

    logic [75:0]   txq   [$];
    logic [75:0]   rxq   [$];
    logic [RW-1:0] sentq [$];
    logic [RW-1:0] exp_rec = '0;
    bit            exp_push = 1'b0;
    bit            exp_err = 1'b0;
    int            nrec = 0;
    string         pfx;

    assign {us_valid, us_crcv, us_crc, us_dvalid,
            us_data, us_protid, us_state} = urec;
    assign drec = {ds_valid, ds_crcv, ds_crc, ds_dvalid,
                   ds_data, ds_protid, ds_state};
    assign rxp = loop_en[g] ? (txp & txr) : inj_v[g];
    assign rxd = loop_en[g] ? txd : inj_d[g][SW-1:0];

    lpif_txrx_gearbox #(
      .DATA_W (64),
      .CRC_W  (2),
      .RATIO  (R)
    ) dut (
      .clk_wr                 (clk),
      .rst_wr_n               (rst_n),
      .ustrm_state            (us_state),
      .ustrm_protid           (us_protid),
      .ustrm_data             (us_data),
      .ustrm_dvalid           (us_dvalid),
      .ustrm_crc              (us_crc),
      .ustrm_crc_valid        (us_crcv),
      .ustrm_valid            (us_valid),
      .ustrm_push             (us_push),
      .ustrm_ready            (us_ready),
      .txfifo_upstream_data   (txd),
      .txfifo_upstream_push   (txp),
      .txfifo_upstream_ready  (txr),
      .rxfifo_downstream_data (rxd),
      .rxfifo_downstream_push (rxp),
      .dstrm_state            (ds_state),
      .dstrm_protid           (ds_protid),
      .dstrm_data             (ds_data),
      .dstrm_dvalid           (ds_dvalid),
      .dstrm_crc              (ds_crc),
      .dstrm_crc_valid        (ds_crcv),
      .dstrm_valid            (ds_valid),
      .dstrm_push             (ds_push),
      .rx_align_err           (aerr)
    );

    // Slice k of a record: marker on k==0, payload bits k*PW.., zero pad.
    function automatic logic [75:0] exp_slice(input logic [RW-1:0] r,
                                              input int k);
      logic [75:0] s;
      s = '0;
      for (int b = 0; b < PW; b++)
        if (k * PW + b < RW) s[b] = r[k*PW+b];
      s[PW] = (k == 0);
      return s;
    endfunction

    initial begin
      logic [95:0] r96;
      pfx = $sformatf("R%0d", R);
      us_push = 1'b0;
      urec = '0;
      txr = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        r96 = {$urandom, $urandom, $urandom};
        urec = r96[RW-1:0];
        us_push = ($urandom_range(99) < push_pct[g]);
        txr = ($urandom_range(99) < rdy_pct[g]);
        if (g == 1 && dir_v) begin
          urec = dir_rec;
          us_push = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      logic [75:0] full;
      if (!rst_n) begin
        check({pfx, "_rst_ready"}, us_ready, 0);
        check({pfx, "_rst_txpush"}, txp, 0);
        check({pfx, "_rst_txdata"}, txd, 0);
        check({pfx, "_rst_dstrm"}, drec, 0);
        check({pfx, "_rst_dpush"}, ds_push, 0);
        check({pfx, "_rst_aerr"}, aerr, 0);
        txq.delete();
        rxq.delete();
        sentq.delete();
        exp_rec = '0;
        exp_push = 1'b0;
        exp_err = 1'b0;
      end else begin
        check({pfx, "_ready"}, us_ready,
              rdy_en && (txq.size() == 0 ||
                         (txq.size() == 1 && txr)));
        check({pfx, "_txpush"}, txp, txq.size() > 0);
        if (txp && txq.size() > 0) begin
          check({pfx, "_txdata"}, txd, txq[0]);
          if (txr) void'(txq.pop_front());
        end
        if (us_push && us_ready) begin
          for (int k = 0; k < R; k++) txq.push_back(exp_slice(urec, k));
          if (loop_en[g]) sentq.push_back(urec);
        end
        check({pfx, "_dpush"}, ds_push, exp_push);
        check({pfx, "_aerr"}, aerr, exp_err);
        check({pfx, "_dstrm"}, drec, exp_rec);
        if (ds_push && loop_en[g]) begin
          check({pfx, "_e2e_avail"}, sentq.size() > 0, 1);
          if (sentq.size() > 0) check({pfx, "_e2e"}, drec, sentq.pop_front());
          nrec++;
        end
        exp_push = 1'b0;
        exp_err = 1'b0;
        if (rxp) begin
          if (rxd[SW-1]) begin
            exp_err = (rxq.size() != 0);
            rxq.delete();
            rxq.push_back({{(76-PW){1'b0}}, rxd[PW-1:0]});
          end else if (rxq.size() == 0) begin
            exp_err = 1'b1;
          end else begin
            rxq.push_back({{(76-PW){1'b0}}, rxd[PW-1:0]});
          end
          if (rxq.size() == R) begin
            full = '0;
            for (int k = 0; k < R; k++)
              for (int b = 0; b < PW; b++) full[k*PW+b] = rxq[k][b];
            exp_rec = full[RW-1:0];
            exp_push = 1'b1;
            rxq.delete();
          end
        end
      end
    end

    initial begin
      wait (done);
      check({pfx, "_drain_tx"}, txq.size(), 0);
      check({pfx, "_drain_e2e"}, sentq.size(), 0);
      check({pfx, "_lb_records"}, nrec >= 100, 1);
    end
  end

  task automatic set_all(input int pp, input int rp);
    for (int i = 0; i < 3; i++) begin
      push_pct[i] = pp;
      rdy_pct[i] = rp;
    end
  endtask

  task automatic inject(input int g, input bit mk);
    int sw;
    logic [95:0] r;
    sw = (RW + (1 << g) - 1) / (1 << g) + 1;
    r = {$urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    inj_v[g] = 1'b1;
    inj_d[g] = r[75:0];
    inj_d[g][sw-1] = mk;
  endtask

  task automatic inject_end(input int g);
    @(posedge clk);
    #1;
    inj_v[g] = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      loop_en[i] = 1'b1;
      inj_v[i] = 1'b0;
      inj_d[i] = '0;
    end
    set_all(0, 100);
    dir_rec = {1'b1, 1'b0, 2'b00, 1'b0,
               64'h0123_4567_89AB_CDEF, 2'b00, 4'h5};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    dir_v = 1'b1;
    @(posedge clk);
    dir_v = 1'b0;
    repeat (8) @(posedge clk);

    set_all(100, 100);
    repeat (40) @(posedge clk);

    rdy_pct[1] = 0;
    repeat (3) @(posedge clk);
    rdy_pct[1] = 100;
    repeat (10) @(posedge clk);

    set_all(60, 70);
    repeat (1500) @(posedge clk);
    set_all(100, 100);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_all(60, 70);
    repeat (1500) @(posedge clk);

    set_all(0, 100);
    repeat (30) @(posedge clk);
    loop_en[0] = 1'b0;
    loop_en[1] = 1'b0;

    inject(1, 1'b0);
    inject(1, 1'b1);
    inject(1, 1'b1);
    inject(1, 1'b0);
    inject(1, 1'b0);
    for (int i = 0; i < 40; i++) inject(1, 1'($urandom_range(1)));
    inject_end(1);

    inject(0, 1'b0);
    inject(0, 1'b1);
    inject(0, 1'b0);
    for (int i = 0; i < 20; i++) inject(0, 1'($urandom_range(1)));
    inject_end(0);

    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
